// File: rtl/radio_tx_pkg.sv
// rtl/radio_tx_pkg.sv - state type, configuration check and item select for the TX burst unpacker
package radio_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    UNDERRUN = 2'd2
  } state_e;

  localparam int unsigned MAX_HOLD_W = 128;

  function automatic bit cfg_ok(input int unsigned nipc, input int unsigned item_w);
    return (nipc == 1 || nipc == 2 || nipc == 4) && (item_w == 16 || item_w == 32);
  endfunction

  // Narrow items come back zero-extended; the caller truncates to ITEM_W.
  function automatic logic [31:0] item_sel(input logic [MAX_HOLD_W-1:0] hold,
                                           input int unsigned idx,
                                           input int unsigned item_w);
    logic [31:0] r;
    r = 32'(hold >> (idx * item_w));
    if (item_w == 16) r[31:16] = '0;
    return r;
  endfunction

endpackage

// File: rtl/radio_tx_burst_unpacker_if.sv
// rtl/radio_tx_burst_unpacker_if.sv - input beat stream bundle between the TX FIFO and the unpacker
interface radio_tx_burst_unpacker_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/radio_tx_burst_unpacker.sv
// rtl/radio_tx_burst_unpacker.sv - unpacks NIPC-item beats into a strobed DAC item stream with burst tracking
module radio_tx_burst_unpacker
  import radio_tx_pkg::*;
#(
  parameter int ITEM_W = 32,
  parameter int NIPC   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                        radio_clk,
  input  logic                        radio_rst_n,
  radio_tx_burst_unpacker_if.slave    s_axis,
  input  logic                        radio_tx_stb,
  output logic [ITEM_W-1:0]           radio_tx_data,
  output logic                        radio_tx_running,
  output logic                        underrun,
  output logic                        burst_done,
  output logic [CNT_W-1:0]            item_count
);

  localparam int HOLD_W = ITEM_W * NIPC;
  localparam int IDX_W  = (NIPC > 1) ? $clog2(NIPC) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIPC - 1);

  if (!cfg_ok(NIPC, ITEM_W)) begin : g_bad_cfg
    $error("radio_tx_burst_unpacker: NIPC must be 1/2/4 and ITEM_W 16/32");
  end

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                underrun_q, underrun_d;
  logic                done_q, done_d;
  logic                accept;
  logic                consumed;

  assign accept   = s_axis.tvalid && s_axis.tready;
  assign consumed = (state_q == RUN) && radio_tx_stb && (idx_q == IDX_LAST);

  always_ff @(posedge radio_clk or negedge radio_rst_n) begin
    if (!radio_rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    underrun_d = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = s_axis.tdata;
          last_d  = s_axis.tlast;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (radio_tx_stb) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          // A finished burst always passes through IDLE, even with the next beat waiting.
          if (consumed) begin
            if (last_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (s_axis.tvalid) begin
              hold_d = s_axis.tdata;
              last_d = s_axis.tlast;
            end else begin
              underrun_d = 1'b1;
              state_d    = UNDERRUN;
            end
          end
        end
      end
      UNDERRUN: begin
        if (accept && s_axis.tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis.tready    = 1'b0;
    radio_tx_running = 1'b0;
    radio_tx_data    = '0;
    unique case (state_q)
      IDLE, UNDERRUN: s_axis.tready = 1'b1;
      RUN: begin
        s_axis.tready    = radio_tx_stb && (idx_q == IDX_LAST) && !last_q;
        radio_tx_running = 1'b1;
        radio_tx_data    = ITEM_W'(item_sel(MAX_HOLD_W'(hold_q), 32'(idx_q), ITEM_W));
      end
      default: ;
    endcase
    // Keep the FIFO stalled for the whole reset, not just until the state register settles.
    if (!radio_rst_n) s_axis.tready = 1'b0;
  end

  assign underrun   = underrun_q;
  assign burst_done = done_q;
  assign item_count = cnt_q;

endmodule

// File: tb/tb_radio_tx_burst_unpacker.sv
// tb/tb_radio_tx_burst_unpacker.sv - randomized self-checking bench for radio_tx_burst_unpacker
module tb_radio_tx_burst_unpacker;

  localparam int NIPC   = 2;
  localparam int ITEM_W = 32;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [63:0] d;
    logic        last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  radio_tx_burst_unpacker_if #(.DATA_W(ITEM_W*NIPC)) m_if ();
  logic              stb = 1'b0;
  logic [ITEM_W-1:0] data;
  logic              running, und, done;
  logic [CNT_W-1:0]  cnt;

  radio_tx_burst_unpacker #(.ITEM_W(ITEM_W), .NIPC(NIPC), .CNT_W(CNT_W)) dut (
    .radio_clk(clk), .radio_rst_n(rst_n), .s_axis(m_if), .radio_tx_stb(stb),
    .radio_tx_data(data), .radio_tx_running(running), .underrun(und),
    .burst_done(done), .item_count(cnt));

  radio_tx_burst_unpacker_if #(.DATA_W(16)) if1 ();
  logic             stb1 = 1'b0;
  logic [15:0]      data1;
  logic             run1, und1, done1;
  logic [CNT_W-1:0] cnt1;

  radio_tx_burst_unpacker #(.ITEM_W(16), .NIPC(1), .CNT_W(CNT_W)) dut1 (
    .radio_clk(clk), .radio_rst_n(rst_n), .s_axis(if1), .radio_tx_stb(stb1),
    .radio_tx_data(data1), .radio_tx_running(run1), .underrun(und1),
    .burst_done(done1), .item_count(cnt1));

  radio_tx_burst_unpacker_if #(.DATA_W(64)) if4 ();
  logic             stb4 = 1'b0;
  logic [15:0]      data4;
  logic             run4, und4, done4;
  logic [CNT_W-1:0] cnt4;

  radio_tx_burst_unpacker #(.ITEM_W(16), .NIPC(4), .CNT_W(CNT_W)) dut4 (
    .radio_clk(clk), .radio_rst_n(rst_n), .s_axis(if4), .radio_tx_stb(stb4),
    .radio_tx_data(data4), .radio_tx_running(run4), .underrun(und4),
    .burst_done(done4), .item_count(cnt4));

  beat_t       src_q[$];
  int          src_idx = 0;
  int          stb_pct = 0;
  int          gap_pct = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs[$];
  logic [31:0] obs1[$];
  logic [31:0] obs4[$];
  int          gaps[$];
  int done_cnt = 0, und_cnt = 0, viol = 0, run_cycles = 0, done1_cnt = 0, done4_cnt = 0;
  int pos = 0, low_len = 0;
  bit seen_high = 1'b0, acc_seen = 1'b0;

  // Observer: played items, pulse counts, idle gaps, and tready/data rule violations.
  always @(negedge clk) begin
    acc_seen = m_if.tvalid && m_if.tready;
    if (running && stb) obs.push_back(data);
    if (running && m_if.tready && !(stb && pos == NIPC-1)) viol++;
    if (!running && data !== '0) viol++;
    pos = !running ? 0 : (stb ? (pos + 1) % NIPC : pos);
    done_cnt   += int'(done);
    und_cnt    += int'(und);
    run_cycles += int'(running);
    if (running) begin
      if (seen_high && low_len > 0) gaps.push_back(low_len);
      seen_high = 1'b1;
      low_len   = 0;
    end else if (seen_high) begin
      low_len++;
    end
    if (run1 && stb1) obs1.push_back(32'(data1));
    if (run4 && stb4) obs4.push_back(32'(data4));
    done1_cnt += int'(done1);
    done4_cnt += int'(done4);
  end

  // Source/sink driver for the main instance; never strobes a beat boundary it cannot refill.
  always @(posedge clk) begin
    bit keep;
    #1;
    if (!rst_n) begin
      m_if.tvalid = 1'b0;
      m_if.tlast  = 1'b0;
      m_if.tdata  = '0;
      stb         = 1'b0;
      src_idx     = src_q.size();
    end else begin
      keep = m_if.tvalid && !acc_seen;
      if (acc_seen) src_idx++;
      if (src_idx < src_q.size() && (keep || $urandom_range(99) >= gap_pct)) begin
        m_if.tvalid = 1'b1;
        m_if.tdata  = src_q[src_idx].d;
        m_if.tlast  = src_q[src_idx].last;
      end else begin
        m_if.tvalid = 1'b0;
      end
      stb = ($urandom_range(99) < stb_pct) &&
            !(running && pos == NIPC-1 && !m_if.tvalid && src_idx < src_q.size());
    end
  end

  function automatic void push_items(input logic [63:0] d, input int nipc, input int w);
    for (int k = 0; k < nipc; k++) exp_q.push_back(32'((d >> (k*w)) & ((64'd1 << w) - 64'd1)));
  endfunction

  task automatic send(input logic [63:0] d, input logic last);
    beat_t b;
    b.d = d;
    b.last = last;
    src_q.push_back(b);
    push_items(d, NIPC, ITEM_W);
  endtask

  task automatic discard(input logic [63:0] d, input logic last);
    beat_t b;
    b.d = d;
    b.last = last;
    src_q.push_back(b);
  endtask

  function automatic int first_diff(input logic [31:0] o[$], input int ob);
    int n;
    n = o.size() - ob;
    for (int i = 0; i < n && i < exp_q.size(); i++) if (o[ob+i] !== exp_q[i]) return i;
    if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
    return -1;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : 'x;
  endfunction

  task automatic wait_settle(input int budget, output bit ok);
    int settle;
    settle = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (src_idx >= src_q.size() && !running && !done && !und && !m_if.tvalid) settle++;
      else settle = 0;
      if (settle >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++; if (data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", data); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
    n_tests++; if (m_if.tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", m_if.tready); end
    n_tests++; if (und !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got und=%b done=%b want 0 0", und, done); end
    n_tests++; if (cnt !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt); end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    n_tests++; if (m_if.tready !== 1'b1) begin n_fail++; $display("FAIL idle_tready: got %b want 1", m_if.tready); end
  endtask

  task automatic test_nominal();
    int ob, db, ub, vb, rb, d;
    bit ok;
    ob = obs.size(); db = done_cnt; ub = und_cnt; vb = viol; rb = run_cycles;
    exp_q.delete();
    stb_pct = 100; gap_pct = 0;
    send({32'h2, 32'h1}, 1'b0);
    send({32'h4, 32'h3}, 1'b1);
    wait_settle(200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL nominal_timeout: got no settle want settle"); end
    d = first_diff(obs, ob);
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL nominal_seq: item %0d got %0h want %0h", d, at(obs, ob+d), at(exp_q, d)); end
    n_tests++; if (done_cnt - db != 1) begin n_fail++; $display("FAIL nominal_done: got %0d want 1", done_cnt - db); end
    n_tests++; if (und_cnt != ub) begin n_fail++; $display("FAIL nominal_underrun: got %0d want 0", und_cnt - ub); end
    n_tests++; if (cnt !== 16'd4) begin n_fail++; $display("FAIL nominal_count: got %0d want 4", cnt); end
    n_tests++; if (run_cycles - rb != 4) begin n_fail++; $display("FAIL nominal_running: got %0d want 4", run_cycles - rb); end
    n_tests++; if (viol != vb) begin n_fail++; $display("FAIL nominal_rules: got %0d want 0", viol - vb); end
  endtask

  task automatic test_throttled();
    int ob, db, ub, vb, d, nb;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      ob = obs.size(); db = done_cnt; ub = und_cnt; vb = viol;
      exp_q.delete();
      stb_pct = 50; gap_pct = 40;
      if (r == 0) begin
        send({32'h2, 32'h1}, 1'b0);
        send({32'h4, 32'h3}, 1'b1);
      end else begin
        nb = $urandom_range(5, 1);
        for (int b = 0; b < nb; b++) send({$urandom, $urandom}, b == nb - 1);
      end
      wait_settle(1000, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL throttled_timeout[%0d]: got no settle want settle", r); end
      d = first_diff(obs, ob);
      n_tests++; if (d >= 0) begin n_fail++; $display("FAIL throttled_seq[%0d]: item %0d got %0h want %0h", r, d, at(obs, ob+d), at(exp_q, d)); end
      n_tests++; if (und_cnt != ub || done_cnt - db != 1) begin n_fail++; $display("FAIL throttled_pulses[%0d]: got und=%0d done=%0d want 0 1", r, und_cnt - ub, done_cnt - db); end
      n_tests++; if (viol != vb) begin n_fail++; $display("FAIL throttled_rules[%0d]: got %0d want 0", r, viol - vb); end
      n_tests++; if (cnt !== CNT_W'(exp_q.size())) begin n_fail++; $display("FAIL throttled_count[%0d]: got %0d want %0d", r, cnt, exp_q.size()); end
    end
  endtask

  task automatic test_underrun();
    int ob, db, ub, d;
    bit ok;
    ob = obs.size(); db = done_cnt; ub = und_cnt;
    exp_q.delete();
    stb_pct = 100; gap_pct = 0;
    send({32'h2, 32'h1}, 1'b0);
    wait_settle(200, ok);
    n_tests++; if (!ok || und_cnt - ub != 1) begin n_fail++; $display("FAIL underrun_pulse: got %0d settled=%b want 1 1", und_cnt - ub, ok); end
    n_tests++; if (running !== 1'b0 || data !== '0) begin n_fail++; $display("FAIL underrun_outputs: got running=%b data=%0h want 0 0", running, data); end
    discard({32'h6, 32'h5}, 1'b0);
    discard({32'h8, 32'h7}, 1'b1);
    wait_settle(200, ok);
    d = first_diff(obs, ob);
    n_tests++; if (!ok || d >= 0) begin n_fail++; $display("FAIL underrun_absorb: item %0d got %0h want %0h", d, at(obs, ob+d), at(exp_q, d)); end
    send({32'hB, 32'hA}, 1'b1);
    wait_settle(200, ok);
    d = first_diff(obs, ob);
    n_tests++; if (!ok || d >= 0) begin n_fail++; $display("FAIL underrun_next_burst: item %0d got %0h want %0h", d, at(obs, ob+d), at(exp_q, d)); end
    n_tests++; if (cnt !== 16'd2) begin n_fail++; $display("FAIL underrun_count: got %0d want 2", cnt); end
    n_tests++; if (done_cnt - db != 1 || und_cnt - ub != 1) begin n_fail++; $display("FAIL underrun_pulses: got done=%0d und=%0d want 1 1", done_cnt - db, und_cnt - ub); end
  endtask

  task automatic test_back_to_back();
    int ob, db, gb, d;
    bit ok;
    ob = obs.size(); db = done_cnt; gb = gaps.size();
    exp_q.delete();
    stb_pct = 100; gap_pct = 0;
    send({32'h12, 32'h11}, 1'b1);
    send({32'h14, 32'h13}, 1'b1);
    wait_settle(200, ok);
    d = first_diff(obs, ob);
    n_tests++; if (!ok || d >= 0) begin n_fail++; $display("FAIL b2b_seq: item %0d got %0h want %0h", d, at(obs, ob+d), at(exp_q, d)); end
    n_tests++; if (done_cnt - db != 2) begin n_fail++; $display("FAIL b2b_done: got %0d want 2", done_cnt - db); end
    n_tests++; if (gaps.size() == gb || gaps[gaps.size()-1] != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want 1", (gaps.size() == gb) ? -1 : gaps[gaps.size()-1]); end
  endtask

  task automatic test_reset_mid_burst();
    int ob, db, ub, d;
    bit ok, got;
    ob = obs.size(); db = done_cnt; ub = und_cnt;
    exp_q.delete();
    stb_pct = 100; gap_pct = 0;
    send({32'h2, 32'h1}, 1'b0);
    send({32'h4, 32'h3}, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (obs.size() - ob >= 1) begin
        got = 1'b1;
        break;
      end
    end
    stb_pct = 0;
    repeat (2) @(posedge clk);
    #3;
    n_tests++; if (!got || data !== 32'h2 || running !== 1'b1) begin n_fail++; $display("FAIL midrst_held: got data=%0h running=%b want 2 1", data, running); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (data !== '0 || running !== 1'b0 || m_if.tready !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got data=%0h running=%b tready=%b want 0 0 0", data, running, m_if.tready); end
    n_tests++; if (cnt !== '0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", cnt); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n_tests++; if (done_cnt != db || und_cnt != ub) begin n_fail++; $display("FAIL midrst_pulses: got done=%0d und=%0d want 0 0", done_cnt - db, und_cnt - ub); end
    exp_q.delete();
    ob = obs.size();
    stb_pct = 100;
    send({32'h22, 32'h21}, 1'b0);
    send({32'h24, 32'h23}, 1'b1);
    wait_settle(200, ok);
    d = first_diff(obs, ob);
    n_tests++; if (!ok || d >= 0) begin n_fail++; $display("FAIL midrst_replay: item %0d got %0h want %0h", d, at(obs, ob+d), at(exp_q, d)); end
    n_tests++; if (cnt !== 16'd4) begin n_fail++; $display("FAIL midrst_replay_count: got %0d want 4", cnt); end
  endtask

  task automatic test_nipc1();
    int ob, db, d, to;
    bit ok;
    logic [15:0] it;
    ob = obs1.size(); db = done1_cnt; to = 0;
    exp_q.delete();
    @(posedge clk);
    #1 stb1 = 1'b1;
    for (int b = 0; b < 8; b++) begin
      it = 16'($urandom);
      push_items(64'(it), 1, 16);
      if1.tdata = it; if1.tlast = (b == 7); if1.tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        ok = if1.tvalid && if1.tready;
        @(posedge clk);
        #1;
        if (ok) break;
      end
      if (!ok) to++;
    end
    if1.tvalid = 1'b0;
    repeat (6) @(posedge clk);
    #1 stb1 = 1'b0;
    d = first_diff(obs1, ob);
    n_tests++; if (to != 0 || d >= 0) begin n_fail++; $display("FAIL nipc1_seq: item %0d got %0h want %0h timeouts=%0d", d, at(obs1, ob+d), at(exp_q, d), to); end
    n_tests++; if (cnt1 !== 16'd8) begin n_fail++; $display("FAIL nipc1_count: got %0d want 8", cnt1); end
    n_tests++; if (done1_cnt - db != 1) begin n_fail++; $display("FAIL nipc1_done: got %0d want 1", done1_cnt - db); end
  endtask

  task automatic test_nipc4();
    int ob, db, d, to;
    bit ok;
    logic [63:0] bd;
    ob = obs4.size(); db = done4_cnt; to = 0;
    exp_q.delete();
    @(posedge clk);
    #1 stb4 = 1'b1;
    for (int b = 0; b < 2; b++) begin
      bd = {$urandom, $urandom};
      push_items(bd, 4, 16);
      if4.tdata = bd; if4.tlast = (b == 1); if4.tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        ok = if4.tvalid && if4.tready;
        @(posedge clk);
        #1;
        if (ok) break;
      end
      if (!ok) to++;
    end
    if4.tvalid = 1'b0;
    repeat (8) @(posedge clk);
    #1 stb4 = 1'b0;
    d = first_diff(obs4, ob);
    n_tests++; if (to != 0 || d >= 0) begin n_fail++; $display("FAIL nipc4_seq: item %0d got %0h want %0h timeouts=%0d", d, at(obs4, ob+d), at(exp_q, d), to); end
    n_tests++; if (cnt4 !== 16'd8) begin n_fail++; $display("FAIL nipc4_count: got %0d want 8", cnt4); end
    n_tests++; if (done4_cnt - db != 1) begin n_fail++; $display("FAIL nipc4_done: got %0d want 1", done4_cnt - db); end
  endtask

  initial begin
    if1.tvalid = 1'b0; if1.tlast = 1'b0; if1.tdata = '0;
    if4.tvalid = 1'b0; if4.tlast = 1'b0; if4.tdata = '0;
    test_reset();
    test_nominal();
    test_throttled();
    test_underrun();
    test_back_to_back();
    test_reset_mid_burst();
    test_nipc1();
    test_nipc4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1);
  end

endmodule
